// File: rtl/stack_pointer_bank_pkg.sv
// Shared encodings and default bounds for the banked stack-pointer unit.
package stack_pkg;

   typedef enum logic [1:0] {
      SP_HOLD = 2'b00,
      SP_ADD  = 2'b01,
      SP_SUB  = 2'b10,
      SP_LOAD = 2'b11
   } sp_op_t;

   localparam logic [31:0] SP_TOP_DEFAULT   = 32'h0000_0400;
   localparam logic [31:0] SP_LIMIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/stack_pointer_bank_sp_next_calc.sv
// Next-value and bound-violation computation for one stack pointer.
module sp_next_calc
   import stack_pkg::*;
#(
   parameter int REG_BITS   = 32,
   parameter int DELTA_BITS = 4
) (
   input  logic [REG_BITS-1:0]   sp_i,
   input  logic [1:0]            op_i,
   input  logic [DELTA_BITS-1:0] delta_i,
   input  logic [REG_BITS-1:0]   load_val_i,
   input  logic [REG_BITS-1:0]   sp_top_i,
   input  logic [REG_BITS-1:0]   sp_limit_i,
   output logic [REG_BITS-1:0]   next_o,
   output logic                  ovf_hit_o,
   output logic                  unf_hit_o
);

   logic [REG_BITS:0] delta_ext_s;
   logic [REG_BITS:0] sum_s;
   logic [REG_BITS:0] diff_s;
   logic              zero_step_s;

   // One extra bit keeps carry and borrow visible as the MSB.
   assign delta_ext_s = {{(REG_BITS + 1 - DELTA_BITS){1'b0}}, delta_i};
   assign sum_s       = {1'b0, sp_i} + delta_ext_s;
   assign diff_s      = {1'b0, sp_i} - delta_ext_s;
   assign zero_step_s = (delta_i == {DELTA_BITS{1'b0}});

   // Decode the operation into a candidate value and its violation flags
   always_comb begin
      next_o    = sp_i;
      ovf_hit_o = 1'b0;
      unf_hit_o = 1'b0;
      case (sp_op_t'(op_i))
         SP_ADD: begin
            next_o    = sum_s[REG_BITS-1:0];
            unf_hit_o = !zero_step_s && (sum_s[REG_BITS] || (sum_s[REG_BITS-1:0] > sp_top_i));
         end
         SP_SUB: begin
            next_o    = diff_s[REG_BITS-1:0];
            ovf_hit_o = !zero_step_s && (diff_s[REG_BITS] || (diff_s[REG_BITS-1:0] < sp_limit_i));
         end
         SP_LOAD: begin
            next_o    = load_val_i;
            ovf_hit_o = (load_val_i < sp_limit_i);
            unf_hit_o = (load_val_i > sp_top_i);
         end
         default: begin
            next_o    = sp_i;
            ovf_hit_o = 1'b0;
            unf_hit_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/stack_pointer_bank.sv
// Banked stack-pointer unit: one SP per bank with hold/add/sub/load updates.
// Bound checking and sticky ovf/unf flags are built only with STACK_BOUNDS_CHECK_EN.
module stack_pointer_bank
   import stack_pkg::*;
#(
   parameter int REG_BITS   = 32,
   parameter int NUM_BANKS  = 2,
   parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   parameter int DELTA_BITS = 4,
   parameter logic [REG_BITS-1:0] SP_TOP   = REG_BITS'(SP_TOP_DEFAULT),
   parameter logic [REG_BITS-1:0] SP_LIMIT = REG_BITS'(SP_LIMIT_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BANK_W-1:0]     bank_sel,
   input  logic [1:0]            op,
   input  logic [DELTA_BITS-1:0] delta,
   input  logic [REG_BITS-1:0]   load_val,
   input  logic                  err_clr,
   output logic [REG_BITS-1:0]   sp_out,
   output logic                  ovf,
   output logic                  unf,
   output logic                  err_pulse
);

   logic [REG_BITS-1:0] sp_q [NUM_BANKS];
   logic [REG_BITS-1:0] sp_cur_s;
   logic [REG_BITS-1:0] next_s;
   logic [REG_BITS-1:0] sp_d;
   logic                bank_ok_s;
   logic                ovf_hit_s;
   logic                unf_hit_s;
   logic                reject_s;
   logic                err_pulse_q;
   logic                err_pulse_d;

   assign bank_ok_s = (32'(bank_sel) < 32'(NUM_BANKS));
   assign sp_cur_s  = bank_ok_s ? sp_q[bank_sel] : '0;
   assign sp_out    = sp_cur_s;
   assign err_pulse = err_pulse_q;

   sp_next_calc #(
      .REG_BITS   (REG_BITS),
      .DELTA_BITS (DELTA_BITS)
   ) u_next (
      .sp_i       (sp_cur_s),
      .op_i       (op),
      .delta_i    (delta),
      .load_val_i (load_val),
      .sp_top_i   (SP_TOP),
      .sp_limit_i (SP_LIMIT),
      .next_o     (next_s),
      .ovf_hit_o  (ovf_hit_s),
      .unf_hit_o  (unf_hit_s)
   );

`ifdef STACK_BOUNDS_CHECK_EN
   logic [NUM_BANKS-1:0] ovf_q;
   logic [NUM_BANKS-1:0] ovf_d;
   logic [NUM_BANKS-1:0] unf_q;
   logic [NUM_BANKS-1:0] unf_d;

   assign reject_s = ovf_hit_s | unf_hit_s;
   assign ovf      = bank_ok_s ? ovf_q[bank_sel] : 1'b0;
   assign unf      = bank_ok_s ? unf_q[bank_sel] : 1'b0;

   // Sticky flags of the selected bank: a new violation beats a clear
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (bank_ok_s) begin
         if (ovf_hit_s) begin
            ovf_d[bank_sel] = 1'b1;
         end else if (err_clr) begin
            ovf_d[bank_sel] = 1'b0;
         end else begin
            ovf_d[bank_sel] = ovf_q[bank_sel];
         end
         if (unf_hit_s) begin
            unf_d[bank_sel] = 1'b1;
         end else if (err_clr) begin
            unf_d[bank_sel] = 1'b0;
         end else begin
            unf_d[bank_sel] = unf_q[bank_sel];
         end
      end else begin
         ovf_d = ovf_q;
         unf_d = unf_q;
      end
   end

   // Flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end
`else
   logic unused_check_s;

   assign unused_check_s = ovf_hit_s | unf_hit_s | err_clr;
   assign reject_s       = 1'b0;
   assign ovf            = 1'b0;
   assign unf            = 1'b0;
`endif

   // Rejected updates leave the selected SP untouched
   always_comb begin
      if (reject_s) begin
         sp_d = sp_cur_s;
      end else begin
         sp_d = next_s;
      end
      err_pulse_d = !bank_ok_s || reject_s;
   end

   // Bank register array; only the addressed bank is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            sp_q[b] <= SP_TOP;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_ok_s && (32'(bank_sel) == 32'(b))) begin
               sp_q[b] <= sp_d;
            end
         end
      end
   end

   // One-cycle error pulse after any rejected update or invalid bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= err_pulse_d;
      end
   end

endmodule

// File: tb/tb_stack_pointer_bank.sv
// Self-checking bench for stack_pointer_bank: directed table, reset corners and random vs. model.
module tb_stack_pointer_bank;

   localparam longint TOP   = 64'h400;
   localparam longint LIMIT = 64'h3F0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:0]  bank_sel = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [3:0]  delta = 4'h0;
   logic [31:0] load_val = 32'h0;
   logic        err_clr = 1'b0;
   logic [31:0] sp_out;
   logic        ovf, unf, err_pulse;

   logic [1:0]  bank_sel3 = 2'b00;
   logic [1:0]  op3 = 2'b00;
   logic [3:0]  delta3 = 4'h0;
   logic [31:0] load3 = 32'h0;
   logic        clr3 = 1'b0;
   logic [31:0] sp3;
   logic        ovf3, unf3, pulse3;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_sp [2];
   bit          m_ovf [2];
   bit          m_unf [2];
   bit          m_pulse;

   typedef struct {
      int          b;
      int          o;
      int          d;
      logic [31:0] lv;
      bit          clr;
      logic [31:0] sp;
      bit          ov;
      bit          un;
      bit          p;
   } vec_t;
   vec_t tbl [$];

   always #5 clk = ~clk;

   stack_pointer_bank #(
      .REG_BITS(32), .NUM_BANKS(2), .DELTA_BITS(4),
      .SP_TOP(32'h0000_0400), .SP_LIMIT(32'h0000_03F0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .op(op), .delta(delta),
      .load_val(load_val), .err_clr(err_clr), .sp_out(sp_out), .ovf(ovf),
      .unf(unf), .err_pulse(err_pulse)
   );

   stack_pointer_bank #(
      .REG_BITS(32), .NUM_BANKS(3), .DELTA_BITS(4),
      .SP_TOP(32'h0000_0400), .SP_LIMIT(32'h0000_03F0)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel3), .op(op3), .delta(delta3),
      .load_val(load3), .err_clr(clr3), .sp_out(sp3), .ovf(ovf3),
      .unf(unf3), .err_pulse(pulse3)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_sp[i]  = 32'h400;
         m_ovf[i] = 1'b0;
         m_unf[i] = 1'b0;
      end
      m_pulse = 1'b0;
   endtask

   // Behavioural rules in plain 64-bit arithmetic
   task automatic model_step(input int b, input int o, input int d, input logic [31:0] lv, input bit clr);
      longint cur, nxt;
      bit ov, un;
      cur = longint'(m_sp[b]);
      nxt = cur;
      ov = 1'b0;
      un = 1'b0;
      if (o == 1) begin
         nxt = cur + d;
         un  = (d != 0) && (nxt > TOP);
      end else if (o == 2) begin
         nxt = cur - d;
         ov  = (d != 0) && (nxt < LIMIT);
      end else if (o == 3) begin
         nxt = longint'(lv);
         ov  = nxt < LIMIT;
         un  = nxt > TOP;
      end
`ifdef STACK_BOUNDS_CHECK_EN
      m_pulse = ov || un;
      if (clr) begin
         m_ovf[b] = 1'b0;
         m_unf[b] = 1'b0;
      end
      if (ov) m_ovf[b] = 1'b1;
      if (un) m_unf[b] = 1'b1;
      if (!(ov || un)) m_sp[b] = nxt[31:0];
`else
      m_pulse  = 1'b0;
      m_sp[b]  = nxt[31:0];
`endif
   endtask

   // Drive one operation, step the model, sample just after the edge
   task automatic apply(input int b, input int o, input int d, input logic [31:0] lv, input bit clr);
      bank_sel = 1'(b);
      op       = 2'(o);
      delta    = 4'(d);
      load_val = lv;
      err_clr  = clr;
      model_step(b, o, d, lv, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int b, input int o, input int d, input logic [31:0] lv, input bit clr,
                      input logic [31:0] sp, input bit ov, input bit un, input bit p);
      vec_t v;
      v = '{b, o, d, lv, clr, sp, ov, un, p};
      tbl.push_back(v);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset values on both banks, read combinationally
      bank_sel = 1'b0; #1;
      chk("rst_sp_b0", sp_out, 32'h400);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_unf", unf, 1'b0);
      chk("rst_pulse", err_pulse, 1'b0);
      bank_sel = 1'b1; #1;
      chk("rst_sp_b1", sp_out, 32'h400);

      // Asynchronous reset in the middle of operation
      apply(0, 3, 0, 32'h3F8, 1'b0);
      chk("pre_rst_sp", sp_out, 32'h3F8);
`ifdef STACK_BOUNDS_CHECK_EN
      apply(0, 2, 15, 32'h0, 1'b0);
      chk("pre_rst_ovf", ovf, 1'b1);
      chk("pre_rst_pulse", err_pulse, 1'b1);
`endif
      op = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_sp", sp_out, 32'h400);
      chk("async_rst_ovf", ovf, 1'b0);
      chk("async_rst_pulse", err_pulse, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

`ifdef STACK_BOUNDS_CHECK_EN
      add(0, 2, 2,  32'h0,   0, 32'h3FE, 0, 0, 0);
      add(0, 1, 1,  32'h0,   0, 32'h3FF, 0, 0, 0);
      add(0, 2, 1,  32'h0,   0, 32'h3FE, 0, 0, 0);
      add(1, 0, 0,  32'h0,   0, 32'h400, 0, 0, 0);
      add(0, 3, 0,  32'h3F4, 0, 32'h3F4, 0, 0, 0);
      add(0, 2, 5,  32'h0,   0, 32'h3F4, 1, 0, 1);
      add(0, 2, 4,  32'h0,   0, 32'h3F0, 1, 0, 0);
      add(0, 0, 0,  32'h0,   1, 32'h3F0, 0, 0, 0);
      add(1, 1, 1,  32'h0,   0, 32'h400, 0, 1, 1);
      add(1, 3, 0,  32'h500, 0, 32'h400, 0, 1, 1);
      add(1, 3, 0,  32'h3F8, 0, 32'h3F8, 0, 1, 0);
      add(1, 1, 15, 32'h0,   1, 32'h3F8, 0, 1, 1);
      add(1, 2, 0,  32'h0,   0, 32'h3F8, 0, 1, 0);
      add(1, 1, 0,  32'h0,   0, 32'h3F8, 0, 1, 0);
      add(1, 0, 0,  32'h0,   1, 32'h3F8, 0, 0, 0);
      add(0, 2, 0,  32'h0,   0, 32'h3F0, 0, 0, 0);
      add(0, 1, 3,  32'h0,   0, 32'h3F3, 0, 0, 0);
      add(1, 2, 2,  32'h0,   0, 32'h3F6, 0, 0, 0);
      add(0, 1, 4,  32'h0,   0, 32'h3F7, 0, 0, 0);
      add(1, 1, 10, 32'h0,   0, 32'h400, 0, 0, 0);
      add(0, 3, 0,  32'h3EF, 0, 32'h3F7, 1, 0, 1);
      add(0, 0, 0,  32'h0,   1, 32'h3F7, 0, 0, 0);
`else
      add(0, 1, 15, 32'h0,   0, 32'h40F, 0, 0, 0);
      add(0, 3, 0,  32'h1,   0, 32'h1, 0, 0, 0);
      add(0, 2, 2,  32'h0,   0, 32'hFFFF_FFFF, 0, 0, 0);
      add(1, 0, 0,  32'h0,   0, 32'h400, 0, 0, 0);
      add(0, 1, 1,  32'h0,   0, 32'h0, 0, 0, 0);
      add(1, 3, 0,  32'h500, 0, 32'h500, 0, 0, 0);
      add(1, 2, 0,  32'h0,   0, 32'h500, 0, 0, 0);
      add(0, 2, 5,  32'h0,   0, 32'hFFFF_FFFB, 0, 0, 0);
      add(1, 1, 0,  32'h0,   0, 32'h500, 0, 0, 0);
      add(0, 0, 0,  32'h0,   1, 32'hFFFF_FFFB, 0, 0, 0);
      add(1, 3, 0,  32'h3F0, 0, 32'h3F0, 0, 0, 0);
      add(1, 2, 1,  32'h0,   0, 32'h3EF, 0, 0, 0);
`endif

      foreach (tbl[i]) begin
         apply(tbl[i].b, tbl[i].o, tbl[i].d, tbl[i].lv, tbl[i].clr);
         chk($sformatf("vec%0d_sp", i), sp_out, tbl[i].sp);
         chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ov);
         chk($sformatf("vec%0d_unf", i), unf, tbl[i].un);
         chk($sformatf("vec%0d_pulse", i), err_pulse, tbl[i].p);
      end

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         int b, o, d;
         logic [31:0] lv;
         bit clr;
         b   = int'($urandom_range(0, 1));
         o   = int'($urandom_range(0, 3));
         d   = int'($urandom_range(0, 15));
         lv  = 32'h3E8 + 32'($urandom_range(0, 40));
         clr = ($urandom_range(0, 7) == 0);
         apply(b, o, d, lv, clr);
         chk("rnd_sp", sp_out, m_sp[b]);
         chk("rnd_ovf", ovf, m_ovf[b]);
         chk("rnd_unf", unf, m_unf[b]);
         chk("rnd_pulse", err_pulse, m_pulse);
      end
      for (int b = 0; b < 2; b++) begin
         apply(b, 0, 0, 32'h0, 1'b0);
         chk("sweep_sp", sp_out, m_sp[b]);
         chk("sweep_ovf", ovf, m_ovf[b]);
         chk("sweep_unf", unf, m_unf[b]);
      end

      // Invalid bank select on a three-bank instance
      bank_sel3 = 2'd3; op3 = 2'b11; load3 = 32'h3F8; clr3 = 1'b1;
      #1;
      chk("inv_sp_comb", sp3, 32'h0);
      chk("inv_ovf", ovf3, 1'b0);
      chk("inv_unf", unf3, 1'b0);
      @(posedge clk); #1;
      chk("inv_pulse", pulse3, 1'b1);
      chk("inv_sp", sp3, 32'h0);
      bank_sel3 = 2'd0; op3 = 2'b00; clr3 = 1'b0;
      #1;
      chk("inv_b0_untouched", sp3, 32'h400);
      @(posedge clk); #1;
      chk("inv_pulse_drop", pulse3, 1'b0);
      bank_sel3 = 2'd2; op3 = 2'b10; delta3 = 4'd1;
      @(posedge clk); #1;
      chk("b2_sub", sp3, 32'h3FF);
      bank_sel3 = 2'd1; op3 = 2'b00;
      #1;
      chk("b1_untouched", sp3, 32'h400);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stack_pointer_bank.md
# stack_pointer_bank

Banked, parametrised stack-pointer unit for the single-cycle core. Holds one stack pointer per bank (e.g. thread or user/interrupt context), applies per-cycle hold/add/subtract/load updates with a variable step, and flags stack overflow/underflow against configured bounds. It sits beside the register file. Its `sp_out` feeds the memory address mux, and the control unit drives `op`, `delta` and `bank_sel`.

## Interface
- `REG_BITS`, 32, stack pointer width.
- `NUM_BANKS`, 2, number of independent stack pointers (≥1).
- `BANK_W`, `$clog2(NUM_BANKS)` (min 1), bank select width.
- `DELTA_BITS`, 4, width of the step operand.
- `SP_TOP`, 32'h0000_0400, reset value and highest legal SP.
- `SP_LIMIT`, 32'h0000_0000, lowest legal SP. The stack grows downward. `SP_LIMIT` must be ≤ `SP_TOP`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bank_sel`  in  BANK_W  bank addressed by `op` and read by `sp_out`.
- `op`  in  2  update mode: 00 hold, 01 SP+delta (pop), 10 SP−delta (push), 11 load.
- `delta`  in  DELTA_BITS  unsigned step.
- `load_val`  in  REG_BITS  value for op 11.
- `err_clr`  in  1  clears sticky flags of the selected bank.
- `sp_out`  out  REG_BITS  current SP of selected bank (combinational read of register).
- `ovf`  out  1  sticky overflow flag of selected bank (push/load below `SP_LIMIT`).
- `unf`  out  1  sticky underflow flag of selected bank (pop/load above `SP_TOP`).
- `err_pulse`  out  1  registered one-cycle pulse on any rejected update.

## Operation
- Only the bank at `bank_sel` updates on a clock edge. All other banks hold.
- op 01: `next = SP + zero_ext(delta)`, computed in REG_BITS+1 bits. A violation is a carry out or `next > SP_TOP`.
- op 10: `next = SP − zero_ext(delta)`, computed in REG_BITS+1 bits. A violation is a borrow or `next < SP_LIMIT`.
- op 11: `next = load_val`.
  - `load_val < SP_LIMIT` is an ovf violation.
  - `load_val > SP_TOP` is an unf violation.
- Legal update: SP ← next.
- Violation, with check enabled:
  - SP holds.
  - The matching sticky flag of that bank sets.
  - `err_pulse` asserts.
- `delta == 0` with op 01/10: no change, no violation.
- `err_clr` with a violation in the same cycle: the set wins (the flag ends at 1).
- `err_clr` with op 00: clears both flags of the selected bank only.
- `bank_sel ≥ NUM_BANKS` (non-power-of-2 counts):
  - op and `err_clr` are ignored.
  - `sp_out`, `ovf` and `unf` read 0.
  - `err_pulse` asserts.

## Timing
- Reset (async, immediate, also mid-operation):
  - every bank SP = `SP_TOP`.
  - all flags = 0, `err_pulse` = 0.
  - `sp_out` = `SP_TOP` for valid `bank_sel`.
- Update latency is one cycle. The value written at edge N is visible on `sp_out` after edge N.
- `sp_out` changes combinationally with `bank_sel`, with no cycle penalty.
- `ovf`/`unf` update on the same edge as the rejected op.
- `err_pulse` is high for exactly the cycle after a rejected op. It stays high on consecutive rejected ops.
- Back-to-back ops on the same bank chain every cycle (no stall, no handshake).

## Configuration
- `STACK_BOUNDS_CHECK_EN` defined:
  - bounds checking as described above.
  - violating updates are suppressed.
- `STACK_BOUNDS_CHECK_EN` not defined:
  - all updates commit.
  - add/sub wrap modulo 2^REG_BITS; load takes any value.
  - `ovf`, `unf` and `err_pulse` tie to 0, except `err_pulse` still reports an invalid `bank_sel`.
  - flag registers are not instantiated.

## Structure
- Shared package `stack_pkg`:
  - op encodings `SP_HOLD`, `SP_ADD`, `SP_SUB`, `SP_LOAD`.
  - default `SP_TOP`/`SP_LIMIT` constants.
  - sp_op_t typedef.
- One sub-module `sp_next_calc`: combinational next-value and violation computation for one SP (inputs: SP, op, delta, load_val, bounds; outputs: next, ovf_hit, unf_hit). It is instantiated once on the selected bank's value.
- The top holds the bank register array, the flags and the `err_pulse` register.

## Test plan
Parameters: REG_BITS=32, NUM_BANKS=2, DELTA_BITS=4, SP_TOP=0x400, SP_LIMIT=0x3F0, check enabled.

1. Reset:
   - release `rst_n`, op 00, bank 0 and 1 → `sp_out`=0x400 on both, `ovf`=`unf`=0.
   - assert `rst_n` low mid-sequence (bank 0 SP=0x3F8) → `sp_out`=0x400 immediately.
2. Bank 0 sequence:
   - sub 2 → 0x3FE.
   - add 1 → 0x3FF.
   - sub 1 → 0x3FE.
   - Then read bank 1 → still 0x400.
3. Overflow:
   - bank 0 at 0x3F4, sub 5 → SP stays 0x3F4, `ovf`=1, `err_pulse` high one cycle.
   - Then sub 4 → 0x3F0 and `ovf` stays 1.
   - `err_clr` → `ovf`=0.
4. Underflow:
   - bank 1 at 0x400, add 1 → holds 0x400, `unf`=1.
   - load 0x500 → holds, `unf`=1.
   - load 0x3F8 → 0x3F8.
   - Then `err_clr` plus add 15 (0x407) in the same cycle → SP holds 0x3F8, `unf` stays 1 (set wins).
5. Edge cases:
   - delta=0 with op 01/10 → no change, no pulse.
   - `bank_sel` switching each cycle with alternating ops → each bank tracks independently.
6. Build without `STACK_BOUNDS_CHECK_EN`:
   - bank 0 at 0x400, add 15 → 0x40F, flags 0.
   - load 0x00000001, sub 2 → 0xFFFFFFFF.
